// File: rtl/dma_bus_scheduler.sv
// Shares the CPU bus between the 6502 core, sprite OAM DMA and DMC sample fetch.
// The core is stalled through cpu_ce while a DMA engine owns the bus.
module dma_bus_scheduler #(
    parameter logic [15:0] OAM_TRIG_ADDR = 16'h4014,
    parameter logic [15:0] OAM_DATA_ADDR = 16'h2004
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        ce,
    input  logic [15:0] cpu_aout,
    input  logic [7:0]  cpu_dout,
    input  logic        cpu_mr,
    input  logic        cpu_mw,
    input  logic [7:0]  din,
    input  logic        dmc_req,
    input  logic [15:0] dmc_addr,
    output logic        cpu_ce,
    output logic [15:0] aout,
    output logic [7:0]  dout,
    output logic        mr,
    output logic        mw,
    output logic        dmc_ack,
    output logic [7:0]  dmc_data,
    output logic        oam_busy,
    output logic [2:0]  state_dbg
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_HALT   = 3'd1,
        S_ALIGN  = 3'd2,
        S_OAM_RD = 3'd3,
        S_OAM_WR = 3'd4,
        S_DMC_RD = 3'd5
    } state_t;

    state_t     state;
    logic       parity;
    logic [7:0] idx;
    logic [7:0] page;
    logic [7:0] oam_data;

    logic dmc_want;
    logic trigger;
    logic pending;

    // DMC handshake: dmc_req is a level held until the dmc_ack pulse. The ack
    // cycle masks the request so the still-high level cannot start a second fetch.
    assign dmc_want  = dmc_req && !dmc_ack;
    assign trigger   = (state == S_IDLE) && cpu_mw && !oam_busy &&
                       (cpu_aout == OAM_TRIG_ADDR);
    assign pending   = oam_busy || dmc_want;
    assign state_dbg = state;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= S_IDLE;
            parity   <= 1'b0;
            idx      <= 8'h00;
            page     <= 8'h00;
            oam_data <= 8'h00;
            dmc_data <= 8'h00;
            dmc_ack  <= 1'b0;
            oam_busy <= 1'b0;
        end else if (ce) begin
            parity  <= ~parity;
            dmc_ack <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (trigger) begin
                        page     <= cpu_dout;
                        oam_busy <= 1'b1;
                    end
                    if (pending && cpu_mr) begin
                        state <= S_HALT;
                    end
                end
                S_HALT: begin
                    // parity=1 means this cycle is PUT, so the next one is GET
                    if (!parity) begin
                        state <= S_ALIGN;
                    end else if (dmc_want) begin
                        state <= S_DMC_RD;
                    end else if (oam_busy) begin
                        state <= S_OAM_RD;
                    end else begin
                        state <= S_IDLE;
                    end
                end
                S_ALIGN: begin
                    if (dmc_want) begin
                        state <= S_DMC_RD;
                    end else if (oam_busy) begin
                        state <= S_OAM_RD;
                    end else begin
                        state <= S_IDLE;
                    end
                end
                S_OAM_RD: begin
                    oam_data <= din;
                    state    <= S_OAM_WR;
                end
                S_OAM_WR: begin
                    idx <= idx + 8'd1;
                    if (idx == 8'hFF) begin
                        oam_busy <= 1'b0;
                        state    <= S_IDLE;
                    end else if (dmc_want) begin
                        state <= S_DMC_RD;
                    end else begin
                        state <= S_OAM_RD;
                    end
                end
                S_DMC_RD: begin
                    dmc_data <= din;
                    dmc_ack  <= 1'b1;
                    // the PUT slot after a steal is burned before OAM resumes on GET
                    state    <= oam_busy ? S_ALIGN : S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    always_comb begin
        cpu_ce = 1'b0;
        aout   = cpu_aout;
        dout   = cpu_dout;
        mr     = 1'b1;
        mw     = 1'b0;
        case (state)
            S_IDLE: begin
                cpu_ce = ce;
                mr     = cpu_mr;
                mw     = cpu_mw;
            end
            S_HALT, S_ALIGN: begin
                aout = cpu_aout;
            end
            S_OAM_RD: begin
                aout = {page, idx};
            end
            S_OAM_WR: begin
                aout = OAM_DATA_ADDR;
                dout = oam_data;
                mr   = 1'b0;
                mw   = 1'b1;
            end
            S_DMC_RD: begin
                aout = dmc_addr;
            end
            default: begin
                cpu_ce = ce;
                mr     = cpu_mr;
                mw     = cpu_mw;
            end
        endcase
    end

endmodule
